// File: rtl/seq_gen_serial_if.sv
// Handshake/data bundle between a sequence controller (master) and the
// serial pattern transmitter (slave).
interface seq_gen_serial_if #(
  parameter int WIDTH = 8,
  parameter int LENW  = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LENW-1:0]  len;
  logic             repeat_en;
  logic             stop;
  logic             x_out;
  logic             valid;
  logic             busy;
  logic             done;
  logic [LENW-1:0]  bit_cnt;

  modport master (
    output start, pattern, len, repeat_en, stop,
    input  x_out, valid, busy, done, bit_cnt
  );

  modport slave (
    input  start, pattern, len, repeat_en, stop,
    output x_out, valid, busy, done, bit_cnt
  );
endinterface

// File: rtl/seq_gen_serial.sv
// Serial bit-sequence transmitter: loads a pattern and shifts it out MSB-first,
// one-shot or continuously repeating, with a busy/done handshake.
module seq_gen_serial #(
  parameter int WIDTH = 8,
  parameter int LENW  = 4
) (
  input logic            clk,
  input logic            clr,
  seq_gen_serial_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_e;

  // Lengths carry one extra bit so len_eff == WIDTH fits even when WIDTH == 2**LENW.
  localparam int            LW      = LENW + 1;
  localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pat_q,   pat_d;
  logic [LW-1:0]    len_q,   len_d;
  logic [LENW-1:0]  cnt_q,   cnt_d;

  logic [LW-1:0]    len_ext;
  logic [LW-1:0]    len_eff;
  logic             last_bit;

  assign len_ext  = {1'b0, bus.len};
  assign len_eff  = (len_ext == '0 || len_ext > WIDTH_L) ? WIDTH_L : len_ext;
  assign last_bit = ({1'b0, cnt_q} == (len_q - LW'(1)));

  // NOTE: every flop is cleared by clr, including the pattern and length
  // holding registers, so nothing from an aborted send survives a reset.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      shreg_q <= shreg_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first, so no path through this block infers a latch.
    state_d = state_q;
    shreg_d = shreg_q;
    pat_d   = pat_q;
    len_d   = len_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pat_d   = bus.pattern;
          len_d   = len_eff;
          shreg_d = bus.pattern << (WIDTH_L - len_eff);
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (!last_bit) begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + LENW'(1);
        end else if (bus.repeat_en && !bus.stop) begin
          // Reload from the held copy so the next pass follows with no gap.
          shreg_d = pat_q << (WIDTH_L - len_q);
          cnt_d   = '0;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.x_out   = 1'b0;
    bus.valid   = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.bit_cnt = '0;

    unique case (state_q)
      S_SEND: begin
        bus.x_out   = shreg_q[WIDTH-1];
        bus.valid   = 1'b1;
        bus.busy    = 1'b1;
        bus.bit_cnt = cnt_q;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_gen_serial.sv
// Self-checking bench for seq_gen_serial: directed scenarios plus random
// stimulus, compared every cycle against a bit-queue reference model.
module tb_seq_gen_serial;
  localparam int WIDTH = 8;
  localparam int LENW  = 4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  seq_gen_serial_if #(.WIDTH(WIDTH), .LENW(LENW)) bus ();

  seq_gen_serial #(.WIDTH(WIDTH), .LENW(LENW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the bits still to be shown this pass (head = on the line now).
  bit               exp_q[$];
  logic [WIDTH-1:0] m_pat;
  int               m_len;
  bit               m_done;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int leff(int l);
    return (l == 0 || l > WIDTH) ? WIDTH : l;
  endfunction

  task automatic push_pass();
    for (int i = m_len - 1; i >= 0; i--) exp_q.push_back(m_pat[i]);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_done = 1'b0;
  endtask

  // Advance the model across one rising edge, using the inputs seen at that edge.
  task automatic model_edge();
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        if (bus.repeat_en && !bus.stop) push_pass();
        else m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (bus.start) begin
      m_pat = bus.pattern;
      m_len = leff(int'(bus.len));
      push_pass();
    end
  endtask

  task automatic compare();
    bit ev;
    ev = (exp_q.size() > 0);
    check("x_out",   32'(bus.x_out),   ev ? 32'(exp_q[0]) : 32'd0);
    check("valid",   32'(bus.valid),   32'(ev));
    check("busy",    32'(bus.busy),    32'(ev));
    check("done",    32'(bus.done),    32'(m_done));
    check("bit_cnt", 32'(bus.bit_cnt), ev ? 32'(m_len - exp_q.size()) : 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    if (clr) model_edge();
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.pattern   = '0;
    bus.len       = '0;
    bus.repeat_en = 1'b0;
    bus.stop      = 1'b0;
  endtask

  // Drops clr between edges and checks that the outputs clear without waiting for a clock.
  task automatic async_reset();
    #2;
    clr = 1'b0;
    model_reset();
    #1;
    compare();
  endtask

  // One-shot send with an independent literal cross-check of the bit stream and timing.
  task automatic run_oneshot(string tag, logic [WIDTH-1:0] pat, logic [LENW-1:0] l,
                             logic [15:0] exp_bits, int exp_n);
    logic [15:0] got  = '0;
    int          n    = 0;
    int          dcyc = 0;
    bit          seen = 1'b0;
    bus.pattern   = pat;
    bus.len       = l;
    bus.repeat_en = 1'b0;
    bus.stop      = 1'b0;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      if (bus.valid) begin
        got = {got[14:0], bus.x_out};
        n++;
      end
      if (bus.done) begin
        seen = 1'b1;
        dcyc = c;
      end
      if (!seen) step();
    end
    step();
    check({tag, "_nbits"},  32'(n),    32'(exp_n));
    check({tag, "_bits"},   32'(got),  32'(exp_bits));
    check({tag, "_done_at"}, 32'(dcyc), 32'(exp_n + 1));
  endtask

  initial begin
    model_reset();
    idle_inputs();
    clr = 1'b0;
    #1;
    compare();
    bus.start = 1'b1;
    step();
    step();
    bus.start = 1'b0;
    clr = 1'b1;
    step();

    // Short and full-length one-shots, including out-of-range length fields.
    run_oneshot("p05_l3",  8'h05, 4'd3,  16'h0005, 3);
    run_oneshot("pA5_l0",  8'hA5, 4'd0,  16'h00A5, 8);
    run_oneshot("pA5_l12", 8'hA5, 4'd12, 16'h00A5, 8);
    run_oneshot("p01_l1",  8'h01, 4'd1,  16'h0001, 1);
    run_oneshot("pFF_l15", 8'hFF, 4'd15, 16'h00FF, 8);

    // Repeat mode with stop raised mid-pass: the third pass still completes.
    bus.pattern = 8'h05; bus.len = 4'd3; bus.repeat_en = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("rep_pass3_bitcnt", 32'(bus.bit_cnt), 32'd1);
    bus.stop = 1'b1;
    for (int i = 0; i < 4; i++) step();
    idle_inputs();
    step();

    // start during an 8-bit pass with another pattern on the bus is ignored.
    bus.pattern = 8'h96; bus.len = 4'd8; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.pattern = 8'h3C; bus.len = 4'd2; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) step();

    // Asynchronous clr at bit 4 of an 8-bit send, then a clean restart.
    bus.pattern = 8'hFF; bus.len = 4'd8; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    async_reset();
    check("clr_drops_valid", 32'(bus.valid), 32'd0);
    bus.start = 1'b1;
    step();
    step();
    bus.start = 1'b0;
    clr = 1'b1;
    step();
    run_oneshot("p0F_l4", 8'h0F, 4'd4, 16'h000F, 4);

    // One-bit pattern repeated continuously until stop.
    bus.pattern = 8'h01; bus.len = 4'd1; bus.repeat_en = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    bus.stop = 1'b1;
    for (int i = 0; i < 3; i++) step();
    idle_inputs();

    // Random traffic, with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.pattern   = WIDTH'($urandom);
      bus.len       = LENW'($urandom);
      bus.repeat_en = ($urandom_range(0, 2) != 0);
      bus.stop      = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
        step();
        clr = 1'b1;
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
